// File: rtl/wrap_tally_display_pkg.sv
// Shared types and constants for the wrap tally display.
// Holds the count limit, BCD digit type, glyph table and BCD increment helper.
package wrap_tally_display_pkg;

    localparam logic [3:0] COUNT_MAX = 4'd10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [3:0] bcd_t;

    // Active-low glyphs {g,f,e,d,c,b,a}, index = digit value
    localparam logic [9:0][6:0] GLYPH = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Returns {carry_out, incremented 4-digit BCD value}
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/wrap_tally_display_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment glyph.
// Ports: i_nib (4-bit digit), o_seg (7-bit {g,f,e,d,c,b,a}, blank for 10..15).
module seg7_decode
    import wrap_tally_display_pkg::*;
(
    input  bcd_t       i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'd0: o_seg = GLYPH[0];
            4'd1: o_seg = GLYPH[1];
            4'd2: o_seg = GLYPH[2];
            4'd3: o_seg = GLYPH[3];
            4'd4: o_seg = GLYPH[4];
            4'd5: o_seg = GLYPH[5];
            4'd6: o_seg = GLYPH[6];
            4'd7: o_seg = GLYPH[7];
            4'd8: o_seg = GLYPH[8];
            4'd9: o_seg = GLYPH[9];
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/wrap_tally_display.sv
// Detects 10->0 wraps of a decade counter, keeps a 4-digit BCD tally with
// sticky overflow/range flags, and scans the tally onto a 4-digit display.
// Ports: clk, reset (async high), count[3:0], clear (sync), wrap_pulse,
// tally[15:0], overflow, range_err, seg[6:0] (active low), an[3:0] (active low).
module wrap_tally_display
    import wrap_tally_display_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  count,
    input  logic        clear,
    output logic        wrap_pulse,
    output logic [15:0] tally,
    output logic        overflow,
    output logic        range_err,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    logic [3:0]    r_prev_count;
    logic          r_wrap_pulse;
    logic [15:0]   r_tally;
    logic          r_overflow;
    logic          r_range_err;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_sel;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_wrap;
    logic [16:0]   w_inc;
    logic          w_tc;
    logic [1:0]    w_sel_next;
    bcd_t          w_nib;
    logic [6:0]    w_seg_next;

    assign w_wrap     = (r_prev_count == COUNT_MAX) && (count == 4'd0);
    assign w_inc      = bcd_inc(r_tally);
    assign w_tc       = (r_presc == PRESC_TC);
    assign w_sel_next = w_tc ? r_sel + 2'd1 : r_sel;

    always_comb begin
        w_nib = r_tally[3:0];
        case (w_sel_next)
            2'd0: w_nib = r_tally[3:0];
            2'd1: w_nib = r_tally[7:4];
            2'd2: w_nib = r_tally[11:8];
            2'd3: w_nib = r_tally[15:12];
            default: w_nib = r_tally[3:0];
        endcase
    end

    seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_count <= 4'd0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_prev_count <= count;
            r_wrap_pulse <= w_wrap;
        end
    end

    // Clear wins over increment and over a same-cycle range error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tally     <= 16'h0000;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
        end else if (clear) begin
            r_tally     <= 16'h0000;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_tally <= w_inc[15:0];
                if (w_inc[16])
                    r_overflow <= 1'b1;
            end
            if (count > COUNT_MAX)
                r_range_err <= 1'b1;
        end
    end

    // seg reloads every edge so tally changes show within one clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_sel   <= 2'd0;
            r_an    <= 4'b1110;
            r_seg   <= 7'b1000000;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + PW'(1);
            r_sel   <= w_sel_next;
            r_an    <= ~(4'b0001 << w_sel_next);
            r_seg   <= w_seg_next;
        end
    end

    assign wrap_pulse = r_wrap_pulse;
    assign tally      = r_tally;
    assign overflow   = r_overflow;
    assign range_err  = r_range_err;
    assign seg        = r_seg;
    assign an         = r_an;

endmodule

// File: tb/tb_wrap_tally_display.sv
// Directed self-checking bench for wrap_tally_display.
// Drives and samples on the falling edge; all expectations are hand-computed.
module tb_wrap_tally_display;

    logic        clk;
    logic        reset;
    logic [3:0]  count;
    logic        clear;
    logic        wrap_pulse;
    logic [15:0] tally;
    logic        overflow;
    logic        range_err;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks;
    int failures;

    wrap_tally_display #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .clear      (clear),
        .wrap_pulse (wrap_pulse),
        .tally      (tally),
        .overflow   (overflow),
        .range_err  (range_err),
        .seg        (seg),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_wrap();
        count = 4'd10;
        tick();
        count = 4'd0;
        tick();
    endtask

    initial begin
        logic [3:0] an_exp [4];
        bit         found;
        an_exp[0] = 4'b1101;
        an_exp[1] = 4'b1011;
        an_exp[2] = 4'b0111;
        an_exp[3] = 4'b1110;
        checks   = 0;
        failures = 0;
        count    = 4'd0;
        clear    = 1'b0;
        reset    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tally", 32'(tally), 32'h0);
        chk("rst_wrap", 32'(wrap_pulse), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_rerr", 32'(range_err), 32'h0);
        chk("rst_an", 32'(an), 32'hE);
        chk("rst_seg", 32'(seg), 32'h40);
        reset = 1'b0;

        // Idle scan, count held at 0 for 20 clocks
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk("idle_wrap", 32'(wrap_pulse), 32'h0);
            if (n == 3)
                chk("scan_hold", 32'(an), 32'hE);
            if (n % 4 == 0) begin
                chk("scan_an", 32'(an), 32'(an_exp[(n / 4 - 1) % 4]));
                chk("scan_seg", 32'(seg), 32'h40);
            end
        end
        chk("idle_tally", 32'(tally), 32'h0);

        // Three full 0..10,0 sweeps
        for (int r = 0; r < 3; r++) begin
            for (int v = 1; v <= 10; v++) begin
                count = 4'(v);
                tick();
                chk("sweep_nowrap", 32'(wrap_pulse), 32'h0);
            end
            count = 4'd0;
            tick();
            chk("sweep_wrap", 32'(wrap_pulse), 32'h1);
            tick();
            chk("sweep_single", 32'(wrap_pulse), 32'h0);
        end
        chk("sweep_tally", 32'(tally), 32'h0003);

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (an == 4'b1110) found = 1'b1;
        end
        chk("units_found", 32'(found), 32'h1);
        chk("units_seg3", 32'(seg), 32'h30);

        // Climb to 9999 then roll over
        for (int i = 0; i < 9996; i++)
            do_wrap();
        chk("tally_9999", 32'(tally), 32'h9999);
        chk("ovf_pre", 32'(overflow), 32'h0);
        do_wrap();
        chk("roll_tally", 32'(tally), 32'h0000);
        chk("roll_ovf", 32'(overflow), 32'h1);
        chk("roll_wrap", 32'(wrap_pulse), 32'h1);
        count = 4'd5;
        repeat (5) tick();
        chk("ovf_sticky", 32'(overflow), 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_tally", 32'(tally), 32'h0);

        // Stall at 10, then 10 -> 5, then out-of-range values
        count = 4'd10;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stall_wrap", 32'(wrap_pulse), 32'h0);
        end
        count = 4'd5;
        tick();
        chk("ten_five_wrap", 32'(wrap_pulse), 32'h0);
        chk("ten_five_tally", 32'(tally), 32'h0);
        chk("rerr_pre", 32'(range_err), 32'h0);
        count = 4'd12;
        tick();
        chk("rerr_set", 32'(range_err), 32'h1);
        count = 4'd0;
        tick();
        chk("rerr_nowrap", 32'(wrap_pulse), 32'h0);
        chk("rerr_sticky", 32'(range_err), 32'h1);

        // Wrap coinciding with clear
        do_wrap();
        chk("pre_clr_tally", 32'(tally), 32'h0001);
        count = 4'd10;
        tick();
        count = 4'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("wc_wrap", 32'(wrap_pulse), 32'h1);
        chk("wc_tally", 32'(tally), 32'h0);
        chk("wc_ovf", 32'(overflow), 32'h0);
        chk("wc_rerr", 32'(range_err), 32'h0);

        // Out-of-range count under clear does not flag
        count = 4'd12;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_rerr_blk", 32'(range_err), 32'h0);
        count = 4'd0;
        tick();

        // Tally 42, flag range error, reset mid-scan
        for (int i = 0; i < 42; i++)
            do_wrap();
        chk("tally_42", 32'(tally), 32'h0042);
        count = 4'd13;
        tick();
        count = 4'd0;
        chk("pre_rst_rerr", 32'(range_err), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (an == 4'b1101) found = 1'b1;
        end
        chk("tens_found", 32'(found), 32'h1);
        chk("tens_seg4", 32'(seg), 32'h19);
        #2 reset = 1'b1;
        #1;
        chk("mid_tally", 32'(tally), 32'h0);
        chk("mid_rerr", 32'(range_err), 32'h0);
        chk("mid_ovf", 32'(overflow), 32'h0);
        chk("mid_wrap", 32'(wrap_pulse), 32'h0);
        chk("mid_an", 32'(an), 32'hE);
        chk("mid_seg", 32'(seg), 32'h40);
        @(negedge clk);
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
